// File: rtl/feature_coord_fifo_if.sv
// rtl/feature_coord_fifo_if.sv - pixel-in / coordinate-stream-out bundle for feature_coord_fifo
interface feature_coord_fifo_if #(
  parameter int IND_WIDTH = 12,
  parameter int CNT_WIDTH = 16,
  parameter int LVL_WIDTH = 9
);
  logic                 frame_start;
  logic [IND_WIDTH-1:0] in_x;
  logic [IND_WIDTH-1:0] in_y;
  logic                 feat_valid;
  logic                 out_valid;
  logic                 out_ready;
  logic [IND_WIDTH-1:0] out_x;
  logic [IND_WIDTH-1:0] out_y;
  logic                 out_sof;
  logic                 frame_done;
  logic [CNT_WIDTH-1:0] last_count;
  logic [CNT_WIDTH-1:0] last_drops;
  logic [LVL_WIDTH-1:0] fifo_level;

  modport master (
    output frame_start, in_x, in_y, feat_valid, out_ready,
    input  out_valid, out_x, out_y, out_sof, frame_done, last_count, last_drops, fifo_level
  );

  modport slave (
    input  frame_start, in_x, in_y, feat_valid, out_ready,
    output out_valid, out_x, out_y, out_sof, frame_done, last_count, last_drops, fifo_level
  );
endinterface

// File: rtl/feature_coord_fifo.sv
// rtl/feature_coord_fifo.sv - capped per-frame FWFT FIFO of feature coordinates with frame stats
// Optional macro FEATURE_BORDER_MASK_EN silently discards flagged pixels inside the image border.
module feature_coord_fifo #(
  parameter int IND_WIDTH     = 12,
  parameter int DEPTH         = 256,
  parameter int MAX_PER_FRAME = 200,
  parameter int CNT_WIDTH     = 16,
  parameter int IM_WIDTH      = 640,
  parameter int IM_HEIGHT     = 480,
  parameter int BORDER        = 3
) (
  input logic                clk,
  input logic                rst,
  feature_coord_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 * IND_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CAP      = CNT_WIDTH'(MAX_PER_FRAME);
  localparam logic [LW-1:0]        FULL_LVL = LW'(DEPTH);

  logic [EW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_drops;
  logic [CNT_WIDTH-1:0] r_last_count;
  logic [CNT_WIDTH-1:0] r_last_drops;
  logic                 r_sof_pending;
  logic                 r_frame_done;

  logic [EW-1:0]        w_head;
  logic                 w_out_valid;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_border_ok;
  logic                 w_sof_tag;
  logic [CNT_WIDTH-1:0] w_eff_count;
  logic [CNT_WIDTH-1:0] w_eff_drops;
  logic [CNT_WIDTH-1:0] w_drops_next;

`ifdef FEATURE_BORDER_MASK_EN
  localparam logic [IND_WIDTH-1:0] X_LO = IND_WIDTH'(BORDER);
  localparam logic [IND_WIDTH-1:0] X_HI = IND_WIDTH'(IM_WIDTH - 1 - BORDER);
  localparam logic [IND_WIDTH-1:0] Y_LO = IND_WIDTH'(BORDER);
  localparam logic [IND_WIDTH-1:0] Y_HI = IND_WIDTH'(IM_HEIGHT - 1 - BORDER);

  assign w_border_ok = (bus.in_x >= X_LO) && (bus.in_x <= X_HI) &&
                       (bus.in_y >= Y_LO) && (bus.in_y <= Y_HI);
`else
  // Geometry only matters when masking is built in; every flagged pixel is eligible.
  assign w_border_ok = 1'b1 | ((IM_WIDTH + IM_HEIGHT + BORDER) != 0);
`endif

  // A frame_start pixel already belongs to the new frame, so it sees cleared counters.
  assign w_eff_count = bus.frame_start ? '0 : r_count;
  assign w_eff_drops = bus.frame_start ? '0 : r_drops;
  assign w_sof_tag   = bus.frame_start | r_sof_pending;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_out_valid = (r_level != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_push      = bus.feat_valid && w_border_ok && (w_eff_count < CAP) &&
                       ((r_level != FULL_LVL) || w_pop);
  assign w_drop      = bus.feat_valid && w_border_ok && !w_push;
  assign w_drops_next = (w_drop && (w_eff_drops != '1)) ? w_eff_drops + 1'b1 : w_eff_drops;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {w_sof_tag, bus.in_y, bus.in_x};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_count       <= '0;
      r_drops       <= '0;
      r_last_count  <= '0;
      r_last_drops  <= '0;
      r_sof_pending <= 1'b1;
      r_frame_done  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (bus.frame_start) begin
        r_last_count <= r_count;
        r_last_drops <= r_drops;
      end
      r_frame_done  <= bus.frame_start;
      r_count       <= w_eff_count + CNT_WIDTH'(w_push);
      r_drops       <= w_drops_next;
      r_sof_pending <= w_sof_tag && !w_push;
    end
  end

  // Head data is gated so the stream reads zero while empty, including straight after reset.
  assign bus.out_valid  = w_out_valid;
  assign bus.out_x      = w_out_valid ? w_head[IND_WIDTH-1:0] : '0;
  assign bus.out_y      = w_out_valid ? w_head[2*IND_WIDTH-1:IND_WIDTH] : '0;
  assign bus.out_sof    = w_out_valid & w_head[EW-1];
  assign bus.frame_done = r_frame_done;
  assign bus.last_count = r_last_count;
  assign bus.last_drops = r_last_drops;
  assign bus.fifo_level = r_level;
endmodule

// File: tb/tb_feature_coord_fifo.sv
// tb/tb_feature_coord_fifo.sv - directed self-checking bench for feature_coord_fifo (DEPTH=4, cap=4)
module tb_feature_coord_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [11:0] t4_x;
  logic [11:0] t4_y;

  always #5 clk = ~clk;

  feature_coord_fifo_if #(.IND_WIDTH(12), .CNT_WIDTH(16), .LVL_WIDTH(3)) u_if ();

  feature_coord_fifo #(
    .IND_WIDTH(12), .DEPTH(4), .MAX_PER_FRAME(4), .CNT_WIDTH(16),
    .IM_WIDTH(640), .IM_HEIGHT(480), .BORDER(3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic fv, input logic [11:0] x, input logic [11:0] y);
    u_if.feat_valid = fv;
    u_if.in_x       = x;
    u_if.in_y       = y;
  endtask

  initial begin
    u_if.frame_start = 1'b0;
    u_if.out_ready   = 1'b0;
    pix(1'b0, 12'd0, 12'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_x", 32'(u_if.out_x), 32'd0);
    chk("rst_y", 32'(u_if.out_y), 32'd0);
    chk("rst_sof", 32'(u_if.out_sof), 32'd0);
    chk("rst_done", 32'(u_if.frame_done), 32'd0);
    chk("rst_cnt", 32'(u_if.last_count), 32'd0);
    chk("rst_drops", 32'(u_if.last_drops), 32'd0);
    chk("rst_level", 32'(u_if.fifo_level), 32'd0);

    // single feature, FWFT latency
    u_if.out_ready = 1'b1;
    pix(1'b1, 12'd5, 12'd7);
    tick();
    pix(1'b0, 12'd0, 12'd0);
    chk("t1_valid", 32'(u_if.out_valid), 32'd1);
    chk("t1_x", 32'(u_if.out_x), 32'd5);
    chk("t1_y", 32'(u_if.out_y), 32'd7);
    chk("t1_sof", 32'(u_if.out_sof), 32'd1);
    tick();
    chk("t1_level_after_pop", 32'(u_if.fifo_level), 32'd0);
    chk("t1_valid_after_pop", 32'(u_if.out_valid), 32'd0);

    // frame boundary reports the single feature
    u_if.frame_start = 1'b1;
    tick();
    u_if.frame_start = 1'b0;
    chk("t2_done0", 32'(u_if.frame_done), 32'd1);
    chk("t2_cnt0", 32'(u_if.last_count), 32'd1);

    // cap: six flagged pixels, four accepted
    for (int k = 0; k < 6; k++) begin
      pix(1'b1, 12'(10 + k), 12'd20);
      tick();
      if (k < 4) begin
        chk($sformatf("t2_x%0d", k), 32'(u_if.out_x), 32'(10 + k));
        chk($sformatf("t2_sof%0d", k), 32'(u_if.out_sof), (k == 0) ? 32'd1 : 32'd0);
      end else begin
        chk($sformatf("t2_valid%0d", k), 32'(u_if.out_valid), 32'd0);
      end
    end
    pix(1'b0, 12'd0, 12'd0);
    chk("t2_done_low", 32'(u_if.frame_done), 32'd0);
    u_if.frame_start = 1'b1;
    tick();
    u_if.frame_start = 1'b0;
    chk("t2_done", 32'(u_if.frame_done), 32'd1);
    chk("t2_cnt", 32'(u_if.last_count), 32'd4);
    chk("t2_drops", 32'(u_if.last_drops), 32'd2);

    // full FIFO, then hold with out_ready low
    u_if.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pix(1'b1, 12'(30 + k), 12'd40);
      tick();
    end
    pix(1'b0, 12'd0, 12'd0);
    chk("t3_level_full", 32'(u_if.fifo_level), 32'd4);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t3_hold_x%0d", k), 32'(u_if.out_x), 32'd30);
      chk($sformatf("t3_hold_y%0d", k), 32'(u_if.out_y), 32'd40);
      chk($sformatf("t3_hold_sof%0d", k), 32'(u_if.out_sof), 32'd1);
    end
    u_if.out_ready   = 1'b1;
    u_if.frame_start = 1'b1;
    pix(1'b1, 12'd50, 12'd60);
    tick();
    u_if.frame_start = 1'b0;
    pix(1'b0, 12'd0, 12'd0);
    chk("t3_level_pushpop", 32'(u_if.fifo_level), 32'd4);
    chk("t3_head_x", 32'(u_if.out_x), 32'd31);
    chk("t3_head_sof", 32'(u_if.out_sof), 32'd0);
    chk("t3_done", 32'(u_if.frame_done), 32'd1);
    chk("t3_cnt", 32'(u_if.last_count), 32'd4);
    chk("t3_drops", 32'(u_if.last_drops), 32'd1);
    tick();
    chk("t3_drain_x32", 32'(u_if.out_x), 32'd32);
    tick();
    chk("t3_drain_x33", 32'(u_if.out_x), 32'd33);
    tick();
    chk("t3_drain_x50", 32'(u_if.out_x), 32'd50);
    chk("t3_drain_y60", 32'(u_if.out_y), 32'd60);
    chk("t3_drain_sof", 32'(u_if.out_sof), 32'd1);
    tick();
    chk("t3_drain_level", 32'(u_if.fifo_level), 32'd0);

    // frame_start together with a feature
`ifdef FEATURE_BORDER_MASK_EN
    t4_x = 12'd3;
    t4_y = 12'd3;
`else
    t4_x = 12'd0;
    t4_y = 12'd0;
`endif
    u_if.frame_start = 1'b1;
    pix(1'b1, t4_x, t4_y);
    tick();
    u_if.frame_start = 1'b0;
    pix(1'b0, 12'd0, 12'd0);
    chk("t4_valid", 32'(u_if.out_valid), 32'd1);
    chk("t4_x", 32'(u_if.out_x), 32'(t4_x));
    chk("t4_y", 32'(u_if.out_y), 32'(t4_y));
    chk("t4_sof", 32'(u_if.out_sof), 32'd1);
    chk("t4_prev_cnt", 32'(u_if.last_count), 32'd1);
    tick();
    u_if.frame_start = 1'b1;
    tick();
    u_if.frame_start = 1'b0;
    chk("t4_cnt", 32'(u_if.last_count), 32'd1);
    chk("t4_drops", 32'(u_if.last_drops), 32'd0);

`ifdef FEATURE_BORDER_MASK_EN
    pix(1'b1, 12'd2, 12'd10);
    tick();
    chk("bm_left_valid", 32'(u_if.out_valid), 32'd0);
    pix(1'b1, 12'd10, 12'd477);
    tick();
    chk("bm_bottom_valid", 32'(u_if.out_valid), 32'd0);
    pix(1'b0, 12'd0, 12'd0);
    u_if.frame_start = 1'b1;
    tick();
    u_if.frame_start = 1'b0;
    chk("bm_cnt", 32'(u_if.last_count), 32'd0);
    chk("bm_drops", 32'(u_if.last_drops), 32'd0);
`endif

    // reset mid-stream with a concurrent push
    u_if.out_ready = 1'b0;
    pix(1'b1, 12'd7, 12'd8);
    tick();
    pix(1'b1, 12'd9, 12'd9);
    tick();
    chk("t5_level_pre", 32'(u_if.fifo_level), 32'd2);
    rst = 1'b1;
    pix(1'b1, 12'd11, 12'd12);
    tick();
    rst = 1'b0;
    pix(1'b0, 12'd0, 12'd0);
    chk("t5_valid", 32'(u_if.out_valid), 32'd0);
    chk("t5_level", 32'(u_if.fifo_level), 32'd0);
    chk("t5_x", 32'(u_if.out_x), 32'd0);
    chk("t5_cnt", 32'(u_if.last_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
